// File: rtl/led_pkg.sv
// Shared constants and types for the LED afterglow PWM driver that sits
// behind the cylon eye pattern generator.
package led_pkg;

    localparam int LED_WIDTH       = 8;
    localparam int LED_PWM_BITS    = 8;
    localparam int LED_DECAY_DIV   = 16;
    localparam int LED_DECAY_SHIFT = 2;

    typedef logic [LED_PWM_BITS-1:0] level_t;

endpackage

// File: rtl/led_decay_channel.sv
// One LED channel: brightness level with exponential afterglow and a
// registered PWM compare against the shared counter.
module led_decay_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS    = LED_PWM_BITS,
    parameter int DECAY_SHIFT = LED_DECAY_SHIFT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lit,
    input  logic                decay_tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                enable,
    output logic                pwm_out
);

    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] level_shr;
    logic [PWM_BITS-1:0] step;

    // Step is at least 1 so every trail reaches 0; it never exceeds level.
    always_comb begin
        level_shr = level >> DECAY_SHIFT;
        step      = (level_shr == '0) ? PWM_BITS'(1) : level_shr;
    end

    // NOTE: reset is sampled on the clock edge (synchronous), and all state
    // updates use non-blocking assignments so every channel sees the same
    // pre-edge pwm_cnt and level values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level   <= '0;
            pwm_out <= 1'b0;
        end else begin
            if (lit) begin
                level <= '1;
            end else if (decay_tick && (level != '0)) begin
                level <= level - step;
            end
            pwm_out <= enable && (pwm_cnt < level);
        end
    end

endmodule

// File: rtl/led_trail_pwm.sv
// Turns the one-hot cylon eye vector into per-LED PWM drive with a fading
// trail; owns the shared PWM counter and the decay prescaler.
module led_trail_pwm
    import led_pkg::*;
#(
    parameter int WIDTH       = LED_WIDTH,
    parameter int PWM_BITS    = LED_PWM_BITS,
    parameter int DECAY_DIV   = LED_DECAY_DIV,
    parameter int DECAY_SHIFT = LED_DECAY_SHIFT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] eyes,
    input  logic             enable,
    output logic [WIDTH-1:0] pwm_out
);

    logic [PWM_BITS-1:0]  pwm_cnt;
    logic [DECAY_DIV-1:0] prescaler;
    logic                 decay_tick;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt   <= '0;
            prescaler <= '0;
        end else begin
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
            prescaler <= prescaler + DECAY_DIV'(1);
        end
    end

    // One tick per prescaler wrap, i.e. every 2^DECAY_DIV cycles.
    assign decay_tick = (prescaler == '1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        led_decay_channel #(
            .PWM_BITS    (PWM_BITS),
            .DECAY_SHIFT (DECAY_SHIFT)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .lit        (eyes[i]),
            .decay_tick (decay_tick),
            .pwm_cnt    (pwm_cnt),
            .enable     (enable),
            .pwm_out    (pwm_out[i])
        );
    end

endmodule
